// File: rtl/ipv4_rx_decoder_pkg.sv
// Shared definitions for the IPv4 receive path: FSM states, error codes and header layout.
package ipv4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_VER_IHL = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_PROTO   = 3'd3;
    localparam logic [2:0] ERR_FRAG    = 3'd4;
    localparam logic [2:0] ERR_LEN     = 3'd5;

    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IHL_MIN      = 4'd5;
    localparam logic [7:0] PROTO_UDP    = 8'd17;

    localparam logic [3:0] HDR_W_FRAG  = 4'd1;
    localparam logic [3:0] HDR_W_PROTO = 4'd2;
    localparam logic [3:0] HDR_W_SRC   = 4'd3;
    localparam logic [3:0] HDR_W_DST   = 4'd4;

    // Keeps the rem valid high bytes of a final word; rem==0 means the word is full.
    function automatic logic [31:0] tail_mask(input logic [1:0] rem);
        logic [31:0] m;
        case (rem)
            2'd1:    m = 32'hFF00_0000;
            2'd2:    m = 32'hFFFF_0000;
            2'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ipv4_rx_decoder_csum.sv
// Ones'-complement 16-bit accumulator over 32-bit words; sum includes the word presented this cycle.
module ip_csum16_acc (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        add,
    input  logic [31:0] word,
    output logic [15:0] sum
);

    logic [15:0] acc;
    logic [15:0] base;
    logic [17:0] raw;
    logic [16:0] fold1;
    logic [15:0] folded;

    // Two folds suffice: the first leaves at most one carry, the second cannot carry again.
    always_comb begin
        base   = clear ? '0 : acc;
        raw    = {2'b00, base} + {2'b00, word[31:16]} + {2'b00, word[15:0]};
        fold1  = {1'b0, raw[15:0]} + {15'd0, raw[17:16]};
        folded = fold1[15:0] + {15'd0, fold1[16]};
        sum    = add ? folded : base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (add || clear) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/ipv4_rx_decoder.sv
// IPv4 receive decoder: validates the header of a word stream and forwards UDP payload words.
module ipv4_rx_decoder
    import ipv4_pkg::*;
#(
    parameter logic       CHECK_HDR_CSUM = 1'b1,
    parameter logic       DROP_FRAGMENTS = 1'b1,
    parameter logic [7:0] PROTO_ACCEPT   = PROTO_UDP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        start_in,
    output logic [31:0] src_ip,
    output logic [31:0] dest_ip,
    output logic [15:0] len_udp,
    output logic [31:0] data_out,
    output logic        start_out,
    output logic        valid_out,
    output logic        last_out,
    output logic        ok,
    output logic        fin,
    output logic [2:0]  err_code
);

    state_t      state;
    logic [3:0]  ihl;
    logic [3:0]  hdr_idx;
    logic [15:0] total_len;
    logic [31:0] src_sh;
    logic [31:0] dest_sh;
    logic        frag_bad;
    logic        proto_bad;
    logic [13:0] words_left;
    logic        first_pay;

    logic [15:0] csum_now;
    logic [15:0] hdr_bytes;
    logic [15:0] udp_len;
    logic [13:0] pay_words;
    logic        word0_bad;
    logic        last_hdr;
    logic        csum_bad;
    logic        len_bad;
    logic [2:0]  hdr_err;

    ip_csum16_acc u_csum (
        .clk   (clk),
        .reset (reset),
        .clear (start_in),
        .add   (start_in || (state == ST_HDR)),
        .word  (data_in),
        .sum   (csum_now)
    );

    always_comb begin
        hdr_bytes = {10'd0, ihl, 2'b00};
        udp_len   = total_len - hdr_bytes;
        pay_words = 14'((udp_len + 16'd3) >> 2);
        word0_bad = (data_in[31:28] != IPV4_VERSION) || (data_in[27:24] < IHL_MIN);
        last_hdr  = (state == ST_HDR) && (hdr_idx == ihl - 4'd1);
        csum_bad  = CHECK_HDR_CSUM && (csum_now != 16'hFFFF);
        len_bad   = total_len < (hdr_bytes + 16'd8);
        // Frag and protocol words always precede the last header word, so their flags are settled here.
        if (csum_bad)       hdr_err = ERR_CSUM;
        else if (proto_bad) hdr_err = ERR_PROTO;
        else if (frag_bad)  hdr_err = ERR_FRAG;
        else if (len_bad)   hdr_err = ERR_LEN;
        else                hdr_err = ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ihl        <= '0;
            hdr_idx    <= '0;
            total_len  <= '0;
            src_sh     <= '0;
            dest_sh    <= '0;
            frag_bad   <= 1'b0;
            proto_bad  <= 1'b0;
            words_left <= '0;
            first_pay  <= 1'b0;
            src_ip     <= '0;
            dest_ip    <= '0;
            len_udp    <= '0;
            data_out   <= '0;
            start_out  <= 1'b0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            ok         <= 1'b0;
            fin        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            start_out <= 1'b0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            ok        <= 1'b0;
            fin       <= 1'b0;
            err_code  <= ERR_NONE;
            data_out  <= '0;
            // A start word always wins: any packet in flight is abandoned without fin.
            if (start_in) begin
                ihl       <= data_in[27:24];
                total_len <= data_in[15:0];
                hdr_idx   <= 4'd1;
                frag_bad  <= 1'b0;
                proto_bad <= 1'b0;
                if (word0_bad) begin
                    fin      <= 1'b1;
                    err_code <= ERR_VER_IHL;
                    state    <= ST_DONE;
                end else begin
                    state <= ST_HDR;
                end
            end else begin
                unique case (state)
                    ST_IDLE: ;
                    ST_HDR: begin
                        hdr_idx <= hdr_idx + 4'd1;
                        if (hdr_idx == HDR_W_FRAG)
                            frag_bad <= DROP_FRAGMENTS && (data_in[13] || (data_in[12:0] != '0));
                        if (hdr_idx == HDR_W_PROTO) proto_bad <= (data_in[23:16] != PROTO_ACCEPT);
                        if (hdr_idx == HDR_W_SRC)   src_sh    <= data_in;
                        if (hdr_idx == HDR_W_DST)   dest_sh   <= data_in;
                        if (last_hdr) begin
                            if (hdr_err != ERR_NONE) begin
                                fin      <= 1'b1;
                                err_code <= hdr_err;
                                state    <= ST_DONE;
                            end else begin
                                src_ip     <= src_sh;
                                dest_ip    <= (hdr_idx == HDR_W_DST) ? data_in : dest_sh;
                                len_udp    <= udp_len;
                                words_left <= pay_words;
                                first_pay  <= 1'b1;
                                state      <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        valid_out  <= 1'b1;
                        start_out  <= first_pay;
                        first_pay  <= 1'b0;
                        words_left <= words_left - 14'd1;
                        if (words_left == 14'd1) begin
                            data_out <= data_in & tail_mask(len_udp[1:0]);
                            last_out <= 1'b1;
                            fin      <= 1'b1;
                            ok       <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            data_out <= data_in;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipv4_rx_decoder.sv
// Bench for ipv4_rx_decoder: directed and random packets checked against a byte-level packet model.
module tb_ipv4_rx_decoder;

    localparam int MAXC = 128;

    typedef struct packed {
        logic        v;
        logic        s;
        logic        l;
        logic        f;
        logic        o;
        logic [2:0]  e;
        logic [31:0] d;
    } out_t;

    typedef struct {
        int          ver;
        int          ihl;
        int          tlen;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        bit          bad_csum;
    } hdr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        start_in = 1'b0;

    logic [31:0] src0, dst0, dout0, src1, dst1, dout1;
    logic [15:0] len0, len1;
    logic        so0, vo0, lo0, ok0, fin0, so1, vo1, lo1, ok1, fin1;
    logic [2:0]  err0, err1;

    out_t        exp_o [2][MAXC];
    logic [79:0] exp_h [2][MAXC];
    logic [79:0] ev_h  [2][MAXC];
    bit          ev_v  [2][MAXC];
    logic [79:0] cur_h [2];
    logic [31:0] st_w  [MAXC];
    bit          st_s  [MAXC];
    bit          st_r  [MAXC];
    int          ncyc;
    int          n_cmp = 0;
    int          n_bad = 0;
    string       tag;

    always #5 clk = ~clk;

    ipv4_rx_decoder dut (
        .clk(clk), .reset(reset), .data_in(data_in), .start_in(start_in),
        .src_ip(src0), .dest_ip(dst0), .len_udp(len0), .data_out(dout0),
        .start_out(so0), .valid_out(vo0), .last_out(lo0), .ok(ok0), .fin(fin0), .err_code(err0)
    );

    ipv4_rx_decoder #(.CHECK_HDR_CSUM(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .data_in(data_in), .start_in(start_in),
        .src_ip(src1), .dest_ip(dst1), .len_udp(len1), .data_out(dout1),
        .start_out(so1), .valid_out(vo1), .last_out(lo1), .ok(ok1), .fin(fin1), .err_code(err1)
    );

    function automatic logic [15:0] ones_sum(input logic [31:0] w[$], input int n);
        int unsigned s = 0;
        for (int i = 0; i < n; i++) s += 32'(w[i][31:16]) + 32'(w[i][15:0]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    function automatic hdr_t spec_hdr();
        hdr_t h;
        h.ver = 4; h.ihl = 5; h.tlen = 39; h.frag = 16'h4000; h.proto = 8'h11;
        h.src = 32'h9801331b; h.dst = 32'h980e5e4b; h.bad_csum = 1'b0;
        return h;
    endfunction

    function automatic hdr_t rand_hdr();
        hdr_t h;
        int   r;
        h.ver = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : 4;
        h.ihl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 8));
        if (h.ihl >= 5)
            h.tlen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4 * h.ihl + 7))
                                                : 4 * h.ihl + 8 + int'($urandom_range(0, 40));
        else
            h.tlen = int'($urandom_range(20, 60));
        r = int'($urandom_range(0, 7));
        if (r == 0)      h.frag = 16'h2000;
        else if (r == 1) h.frag = {3'b000, 13'($urandom_range(1, 8191))};
        else if (r == 2) h.frag = 16'h0000;
        else             h.frag = 16'h4000;
        h.proto    = ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h11;
        h.src      = $urandom;
        h.dst      = $urandom;
        h.bad_csum = ($urandom_range(0, 7) == 0);
        return h;
    endfunction

    task automatic clear_run(input string t);
        tag = t;
        ncyc = 0;
        for (int c = 0; c < MAXC; c++) begin
            st_w[c] = $urandom; st_s[c] = 1'b0; st_r[c] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                exp_o[d][c] = '0; ev_v[d][c] = 1'b0; ev_h[d][c] = '0;
            end
        end
    endtask

    // Places one packet starting at cycle base; model outputs at relative cycle >= cut are discarded.
    task automatic add_packet(input int base, input int cut, input hdr_t h);
        logic [31:0] hw[$];
        logic [31:0] pay[$];
        logic [7:0]  pb[$];
        logic [31:0] ew, m;
        logic [15:0] ck;
        out_t        o;
        int          hlen, plen, npay, e, t;
        bit          len_ok;
        hlen = (h.ihl > 5) ? h.ihl : 5;
        hw.push_back({4'(h.ver), 4'(h.ihl), 8'($urandom), 16'(h.tlen)});
        hw.push_back({16'($urandom), h.frag});
        hw.push_back({8'($urandom), h.proto, 16'h0000});
        hw.push_back(h.src);
        hw.push_back(h.dst);
        for (int i = 5; i < hlen; i++) hw.push_back($urandom);
        if (h.ihl >= 5) begin
            ck = ~ones_sum(hw, h.ihl);
            if (h.bad_csum) ck = ck ^ 16'h0001;
            hw[2] = {hw[2][31:16], ck};
        end
        len_ok = (h.ihl >= 5) && (h.tlen >= 4 * h.ihl + 8);
        plen   = len_ok ? h.tlen - 4 * h.ihl : 0;
        npay   = (plen + 3) / 4;
        for (int i = 0; i < plen; i++) pb.push_back(8'($urandom));
        for (int k = 0; k < hlen; k++)
            if (base + k < MAXC) begin st_w[base + k] = hw[k]; st_s[base + k] = (k == 0); end
        for (int j = 0; j < npay; j++) begin
            ew = '0; m = '0;
            for (int b = 0; b < 4; b++)
                if (4 * j + b < plen) begin
                    ew = ew | (32'(pb[4 * j + b]) << (24 - 8 * b));
                    m  = m  | (32'hFF << (24 - 8 * b));
                end
            pay.push_back(ew);
            if (base + hlen + j < MAXC) begin
                st_w[base + hlen + j] = ew | ($urandom & ~m);
                st_s[base + hlen + j] = 1'b0;
            end
        end
        if (base + hlen + npay + 3 > ncyc) ncyc = base + hlen + npay + 3;
        for (int d = 0; d < 2; d++) begin
            e = 0;
            if (h.ver != 4 || h.ihl < 5)                             e = 1;
            else if (d == 0 && ones_sum(hw, h.ihl) != 16'hFFFF)      e = 2;
            else if (h.proto != 8'd17)                               e = 3;
            else if (h.frag[13] || h.frag[12:0] != 13'd0)            e = 4;
            else if (!len_ok)                                        e = 5;
            if (e != 0) begin
                t = (e == 1) ? 1 : h.ihl;
                o = '0; o.f = 1'b1; o.e = 3'(e);
                if (t < cut && base + t < MAXC) exp_o[d][base + t] = o;
            end else begin
                t = h.ihl;
                if (t < cut && base + t < MAXC) begin
                    ev_v[d][base + t] = 1'b1;
                    ev_h[d][base + t] = {h.src, h.dst, 16'(plen)};
                end
                for (int j = 0; j < npay; j++) begin
                    t = h.ihl + 1 + j;
                    o = '0; o.v = 1'b1; o.s = (j == 0); o.d = pay[j];
                    if (j == npay - 1) begin o.l = 1'b1; o.f = 1'b1; o.o = 1'b1; end
                    if (t < cut && base + t < MAXC) exp_o[d][base + t] = o;
                end
            end
        end
    endtask

    task automatic get_obs(input int d, output out_t o, output logic [79:0] hh);
        if (d == 0) begin
            o  = {vo0, so0, lo0, fin0, ok0, err0, dout0};
            hh = {src0, dst0, len0};
        end else begin
            o  = {vo1, so1, lo1, fin1, ok1, err1, dout1};
            hh = {src1, dst1, len1};
        end
    endtask

    task automatic check_cycle(input int c);
        out_t        o;
        logic [79:0] hh;
        for (int d = 0; d < 2; d++) begin
            get_obs(d, o, hh);
            n_cmp++;
            assert (o === exp_o[d][c]) else begin
                n_bad++;
                $error("FAIL %s out dut%0d cyc%0d got=%h exp=%h", tag, d, c, o, exp_o[d][c]);
            end
            n_cmp++;
            assert (hh === exp_h[d][c]) else begin
                n_bad++;
                $error("FAIL %s held dut%0d cyc%0d got=%h exp=%h", tag, d, c, hh, exp_h[d][c]);
            end
        end
    endtask

    task automatic run();
        for (int d = 0; d < 2; d++) begin
            exp_h[d][0] = cur_h[d];
            for (int c = 1; c < MAXC; c++) exp_h[d][c] = ev_v[d][c] ? ev_h[d][c] : exp_h[d][c - 1];
        end
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            if (c > 0) check_cycle(c);
            if (c < ncyc) begin
                data_in = st_w[c]; start_in = st_s[c]; reset = st_r[c];
            end else begin
                start_in = 1'b0; reset = 1'b0;
            end
        end
        for (int d = 0; d < 2; d++) cur_h[d] = exp_h[d][ncyc];
    endtask

    task automatic one(input string t, input hdr_t h);
        clear_run(t);
        add_packet(0, MAXC, h);
        run();
    endtask

    initial begin
        hdr_t h, h2;
        out_t o;
        logic [79:0] hh;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            get_obs(d, o, hh);
            n_cmp++;
            assert (o === '0) else begin n_bad++; $error("FAIL reset_out dut%0d got=%h exp=0", d, o); end
            n_cmp++;
            assert (hh === '0) else begin n_bad++; $error("FAIL reset_held dut%0d got=%h exp=0", d, hh); end
            cur_h[d] = '0;
        end
        reset = 1'b0;

        one("good", spec_hdr());
        n_cmp++;
        assert ({src0, dst0, len0} === {32'h9801331b, 32'h980e5e4b, 16'h0013}) else begin
            n_bad++;
            $error("FAIL good_held got=%h exp=9801331b980e5e4b0013", {src0, dst0, len0});
        end

        h = spec_hdr(); h.bad_csum = 1'b1;  one("bad_csum", h);
        h = spec_hdr(); h.proto = 8'h06;    one("proto6", h);
        h = spec_hdr(); h.frag = 16'h2000;  one("mf", h);
        h = spec_hdr(); h.ihl = 6;          one("ihl6", h);
        h = spec_hdr(); h.ver = 5;          one("ver5", h);
        h = spec_hdr(); h.tlen = 27;        one("short", h);

        clear_run("reset_mid");
        add_packet(0, 8, spec_hdr());
        st_r[7] = 1'b1;
        for (int d = 0; d < 2; d++) begin ev_v[d][8] = 1'b1; ev_h[d][8] = '0; end
        h2 = spec_hdr(); h2.src = 32'h0a000001; h2.dst = 32'h0a000002;
        add_packet(10, MAXC, h2);
        run();

        clear_run("restart");
        h = spec_hdr(); h.tlen = 60;
        add_packet(0, 8, h);
        h2 = spec_hdr(); h2.src = 32'hc0a80101; h2.tlen = 34;
        add_packet(7, MAXC, h2);
        run();

        for (int i = 0; i < 40; i++) one($sformatf("rand%0d", i), rand_hdr());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
